multicycle_control: RTL and testbench

//  Multicycle MIPS main control FSM; the producer side of the ALUOp/JumpRegister interface

---
 rtl/mips_pkg.sv | 100 ++++++++++
 rtl/mc_output_decode.sv | 109 ++++++++++
 rtl/multicycle_control.sv | 93 +++++++++
 tb/tb_multicycle_control.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALUOp class codes,
// FSM state encodings, datapath mux select codes and the packed control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUOp class codes; ALUControl decodes exactly these values
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;
  localparam logic [2:0] ALU_ANDI  = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_R_EXEC = 4'd2,
    S_R_WB   = 4'd3,
    S_I_EXEC = 4'd4,
    S_I_WB   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_MEM_WB = 4'd8,
    S_MEM_WR = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // State following DECODE; S_FETCH doubles as the "unsupported opcode" result
  function automatic state_t decode_next(input logic [5:0] op, input bit enable_jal);
    state_t nxt;
    case (op)
      OP_RTYPE:                  nxt = S_R_EXEC;
      OP_LW, OP_SW:              nxt = S_ADDR;
      OP_BEQ, OP_BNE:            nxt = S_BRANCH;
      OP_J:                      nxt = S_JUMP;
      OP_JAL:                    nxt = enable_jal ? S_JAL : S_FETCH;
      OP_ADDI, OP_ORI, OP_ANDI:  nxt = S_I_EXEC;
      default:                   nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      OP_ORI:  code = ALU_ORI;
      OP_ANDI: code = ALU_ANDI;
      default: code = ALU_ADDI;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode from FSM state, opcodes and the ALU/ALUControl feedback.
// Reset overrides every write enable so a reset mid-instruction cannot commit anything.
module mc_output_decode
  import mips_pkg::*;
#(
  parameter bit ENABLE_JAL = 1'b1
) (
  input  logic       reset,
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] opcode_q,
  input  logic       jump_register,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = (decode_next(opcode, ENABLE_JAL) == S_FETCH);
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_RTYPE;
        if (jump_register) begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_RS;
        end
      end
      S_R_WB: begin
        ctrl.reg_dst    = DST_RD;
        ctrl.mem_to_reg = WB_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = itype_alu_op(opcode_q);
      end
      S_I_WB: begin
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = WB_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = WB_MDR;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_BRANCH: begin
        // Branch decision is resolved here so the datapath sees a plain load strobe
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = ((opcode_q == OP_BEQ) &&  zero) ||
                             ((opcode_q == OP_BNE) && !zero);
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_dst    = DST_RA;
        ctrl.mem_to_reg = WB_PC;
        ctrl.reg_write  = 1'b1;
      end
      default: ;
    endcase

    if (reset) begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.alu_op        = ALU_ADD;
      ctrl.illegal_op    = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: state register, opcode latch and next-state logic;
// the per-state control word comes from mc_output_decode.
module multicycle_control
  import mips_pkg::*;
#(
  parameter bit ENABLE_JAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       jump_register_i,
  input  logic       zero_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic [1:0] reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [2:0] alu_op_o,
  output logic       illegal_op_o,
  output logic [3:0] state_o
);

  state_t     state;
  state_t     state_next;
  logic [5:0] opcode_q;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // IR may change after DECODE, so every later state works from this copy
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q <= '0;
    end else if (state == S_DECODE) begin
      opcode_q <= opcode_i;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = decode_next(opcode_i, ENABLE_JAL);
      S_R_EXEC: state_next = jump_register_i ? S_FETCH : S_R_WB;
      S_I_EXEC: state_next = S_I_WB;
      S_ADDR:   state_next = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_next = S_MEM_WB;
      default:  state_next = S_FETCH;
    endcase
  end

  mc_output_decode #(
    .ENABLE_JAL(ENABLE_JAL)
  ) u_output_decode (
    .reset        (reset),
    .state        (state),
    .opcode       (opcode_i),
    .opcode_q     (opcode_q),
    .jump_register(jump_register_i),
    .zero         (zero_i),
    .ctrl         (ctrl)
  );

  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign i_or_d_o        = ctrl.i_or_d;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign ir_write_o      = ctrl.ir_write;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_dst_o       = ctrl.reg_dst;
  assign reg_write_o     = ctrl.reg_write;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign pc_source_o     = ctrl.pc_source;
  assign alu_op_o        = ctrl.alu_op;
  assign illegal_op_o    = ctrl.illegal_op;
  assign state_o         = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model queues the expected
// per-cycle control word, and a negedge monitor pops and compares whatever the DUT presents.
module tb_multicycle_control;
  import mips_pkg::*;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic [1:0] m2r;
    logic [1:0] rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] psrc;
    logic [2:0] aluop;
    logic       ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode_i = '0;
  logic       jump_register_i = 1'b0;
  logic       zero_i = 1'b0;
  logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic [1:0] mem_to_reg_o, reg_dst_o, alu_src_b_o, pc_source_o;
  logic       reg_write_o, alu_src_a_o, illegal_op_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  logic       reset2 = 1'b1;
  logic [5:0] opcode2 = '0;
  logic       n_pcw, n_pcwc, n_iord, n_mr, n_mw, n_irw, n_rw, n_asa, n_ill;
  logic [1:0] n_m2r, n_rdst, n_asb, n_psrc;
  logic [2:0] n_aluop;
  logic [3:0] n_state;

  int   compared = 0;
  int   mismatched = 0;
  logic monitorOn = 1'b1;
  logic wasReset = 1'b1;
  ctl_t actual;
  ctl_t expQ[$];
  ctl_t maskQ[$];
  string tagQ[$];

  always #5 clk = ~clk;

  multicycle_control #(.ENABLE_JAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .jump_register_i(jump_register_i), .zero_i(zero_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .i_or_d_o(i_or_d_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .pc_source_o(pc_source_o),
    .alu_op_o(alu_op_o), .illegal_op_o(illegal_op_o), .state_o(state_o)
  );

  multicycle_control #(.ENABLE_JAL(1'b0)) dutNoJal (
    .clk(clk), .reset(reset2), .opcode_i(opcode2), .jump_register_i(1'b0), .zero_i(1'b0),
    .pc_write_o(n_pcw), .pc_write_cond_o(n_pcwc), .i_or_d_o(n_iord),
    .mem_read_o(n_mr), .mem_write_o(n_mw), .ir_write_o(n_irw),
    .mem_to_reg_o(n_m2r), .reg_dst_o(n_rdst), .reg_write_o(n_rw),
    .alu_src_a_o(n_asa), .alu_src_b_o(n_asb), .pc_source_o(n_psrc),
    .alu_op_o(n_aluop), .illegal_op_o(n_ill), .state_o(n_state)
  );

  assign actual = {pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
                   mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                   pc_source_o, alu_op_o, illegal_op_o};

  task automatic checkOutput(input string name, input ctl_t act, input ctl_t exp, input ctl_t mask);
    compared++;
    if (((act ^ exp) & mask) != '0) begin
      mismatched++;
      $display("[TB] FAIL %s: got %05h expected %05h (care mask %05h) at %0t", name, act, exp, mask, $time);
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction class -> list of per-cycle control expectations
  function automatic logic modelLegal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
      6'b000010, 6'b000011, 6'b001000, 6'b001101, 6'b001100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void startCycle(output ctl_t e, output ctl_t m);
    e = '0;
    m = '0;
    m.pcw = 1'b1; m.pcwc = 1'b1; m.mr = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.rw = 1'b1; m.ill = 1'b1;
  endfunction

  function automatic void pushCycle(input ctl_t e, input ctl_t m, input logic [5:0] op, input int idx);
    expQ.push_back(e);
    maskQ.push_back(m);
    tagQ.push_back($sformatf("op%06b_cycle%0d", op, idx));
  endfunction

  task automatic modelInstr(input logic [5:0] op, input logic jr, input logic zero, output int len);
    ctl_t e, m;
    len = 0;
    startCycle(e, m);
    e.mr = 1; e.irw = 1; e.pcw = 1; e.asb = 2'b01;
    m.iord = 1; m.asa = 1; m.asb = '1; m.aluop = '1; m.psrc = '1;
    pushCycle(e, m, op, len++);
    startCycle(e, m);
    e.asb = 2'b11; e.ill = !modelLegal(op);
    m.asa = 1; m.asb = '1; m.aluop = '1;
    pushCycle(e, m, op, len++);
    if (!modelLegal(op)) return;
    startCycle(e, m);
    case (op)
      6'b000000: begin
        e.asa = 1; e.aluop = 3'b111; m.asa = 1; m.asb = '1; m.aluop = '1;
        if (jr) begin
          e.pcw = 1; e.psrc = 2'b11; m.psrc = '1;
          pushCycle(e, m, op, len++);
        end else begin
          pushCycle(e, m, op, len++);
          startCycle(e, m);
          e.rw = 1; e.rdst = 2'b01; m.rdst = '1; m.m2r = '1;
          pushCycle(e, m, op, len++);
        end
      end
      6'b001000, 6'b001101, 6'b001100: begin
        e.asa = 1; e.asb = 2'b10; m.asa = 1; m.asb = '1; m.aluop = '1;
        e.aluop = (op == 6'b001000) ? 3'b100 : (op == 6'b001101) ? 3'b101 : 3'b110;
        pushCycle(e, m, op, len++);
        startCycle(e, m);
        e.rw = 1; m.rdst = '1; m.m2r = '1;
        pushCycle(e, m, op, len++);
      end
      6'b100011, 6'b101011: begin
        e.asa = 1; e.asb = 2'b10; m.asa = 1; m.asb = '1; m.aluop = '1;
        pushCycle(e, m, op, len++);
        startCycle(e, m);
        e.iord = 1; m.iord = 1;
        if (op == 6'b100011) begin
          e.mr = 1;
          pushCycle(e, m, op, len++);
          startCycle(e, m);
          e.rw = 1; e.m2r = 2'b01; m.rdst = '1; m.m2r = '1;
          pushCycle(e, m, op, len++);
        end else begin
          e.mw = 1;
          pushCycle(e, m, op, len++);
        end
      end
      6'b000100, 6'b000101: begin
        e.asa = 1; e.aluop = 3'b001; e.psrc = 2'b01;
        e.pcwc = (op == 6'b000100) ? zero : !zero;
        m.asa = 1; m.asb = '1; m.aluop = '1; m.psrc = '1;
        pushCycle(e, m, op, len++);
      end
      default: begin
        e.pcw = 1; e.psrc = 2'b10; m.psrc = '1;
        if (op == 6'b000011) begin
          e.rw = 1; e.rdst = 2'b10; e.m2r = 2'b10; m.rdst = '1; m.m2r = '1;
        end
        pushCycle(e, m, op, len++);
      end
    endcase
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic jr, input logic zero);
    int len;
    modelInstr(op, jr, zero, len);
    opcode_i = op;
    jump_register_i = jr;
    zero_i = zero;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) opcode_i = 6'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (monitorOn) begin
      if (reset) begin
        ctl_t rm;
        rm = '0;
        rm.pcw = 1; rm.pcwc = 1; rm.mw = 1; rm.irw = 1; rm.rw = 1; rm.aluop = '1;
        checkOutput("reset_gating", actual, '0, rm);
      end else begin
        if (wasReset) checkValue("state_after_reset", {4'b0, state_o}, {4'b0, S_FETCH});
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL scoreboard_empty: got an active cycle, expected no pending entry at %0t", $time);
        end else begin
          checkOutput(tagQ.pop_front(), actual, expQ.pop_front(), maskQ.pop_front());
        end
      end
      wasReset = reset;
    end
  end

  initial begin
    logic [5:0] legalOps[10];
    legalOps = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                 6'b000010, 6'b000011, 6'b001000, 6'b001101, 6'b001100};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(6'b000000, 1'b0, 1'b0);
    applyStimulus(6'b000000, 1'b1, 1'b0);
    applyStimulus(6'b000100, 1'b0, 1'b1);
    applyStimulus(6'b000101, 1'b0, 1'b1);
    applyStimulus(6'b000100, 1'b0, 1'b0);
    applyStimulus(6'b000101, 1'b0, 1'b0);
    applyStimulus(6'b100011, 1'b1, 1'b0);
    applyStimulus(6'b101011, 1'b0, 1'b1);
    applyStimulus(6'b001000, 1'b1, 1'b1);
    applyStimulus(6'b001101, 1'b0, 1'b0);
    applyStimulus(6'b001100, 1'b1, 1'b0);
    applyStimulus(6'b000010, 1'b0, 1'b0);
    applyStimulus(6'b000011, 1'b1, 1'b1);
    applyStimulus(6'b111111, 1'b0, 1'b0);

    // lw abandoned in MEM_RD: only FETCH/DECODE/ADDR are expected before reset takes over
    begin
      int len;
      modelInstr(6'b100011, 1'b0, 1'b0, len);
      void'(expQ.pop_back()); void'(maskQ.pop_back()); void'(tagQ.pop_back());
      void'(expQ.pop_back()); void'(maskQ.pop_back()); void'(tagQ.pop_back());
      opcode_i = 6'b100011;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
    end

    for (int i = 0; i < 300; i++) begin
      int r;
      logic [5:0] op;
      r = $urandom_range(0, 11);
      op = (r < 10) ? legalOps[r] : 6'($urandom_range(0, 63));
      applyStimulus(op, 1'($urandom), 1'($urandom));
    end

    monitorOn = 1'b0;
    checkValue("scoreboard_drained", 8'(expQ.size()), 8'd0);
    reset = 1'b1;

    // JAL opcode on a core built without JAL support
    opcode2 = 6'b000011;
    @(posedge clk);
    #1 reset2 = 1'b0;
    @(negedge clk);
    checkValue("nojal_fetch_state", {4'b0, n_state}, {4'b0, S_FETCH});
    @(negedge clk);
    checkValue("nojal_illegal_pulse", {7'b0, n_ill}, 8'd1);
    checkValue("nojal_no_writes", {3'b0, n_pcw, n_pcwc, n_mw, n_irw, n_rw}, 8'd0);
    @(negedge clk);
    checkValue("nojal_back_to_fetch", {4'b0, n_state}, {4'b0, S_FETCH});
    checkValue("nojal_pulse_ends", {7'b0, n_ill}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
